// File: rtl/CPU_package.sv
// Shared CPU types: datapath width, ALU opcode/flag types and the multiplier sequencer states.
// The optional signed-multiply build (ALU_MUL_SEQ_SIGNED_EN) uses abs_val below.
package CPU_package;

  localparam int unsigned DATA_WIDTH = 16;

  typedef enum logic [2:0] {
    ALU_OP_ADD,
    ALU_OP_SUB,
    ALU_OP_AND,
    ALU_OP_OR,
    ALU_OP_XOR
  } enum_alu_opcode_t;

  typedef struct packed {
    logic carry;
    logic zero;
    logic negative;
    logic overflow;
  } struct_alu_flag_t;

  typedef enum logic [1:0] {
    MUL_IDLE,
    MUL_RUN,
    MUL_FIX,
    MUL_DONE
  } enum_mul_state_t;

  // Two's-complement magnitude; the most negative value maps to itself read as unsigned.
  function automatic logic [DATA_WIDTH-1:0] abs_val(input logic [DATA_WIDTH-1:0] v);
    return v[DATA_WIDTH-1] ? (~v + DATA_WIDTH'(1)) : v;
  endfunction

endpackage

// File: rtl/ALU.sv
// Shared combinational ALU of the 16-bit CPU.
// mode=1 selects arithmetic flag reporting (carry/overflow); mode=0 reports them as 0.
module ALU
  import CPU_package::*;
(
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic                  input_carry,
  input  enum_alu_opcode_t      opcode,
  input  logic                  mode,
  output logic [DATA_WIDTH-1:0] out,
  output struct_alu_flag_t      out_flag
);

  logic [DATA_WIDTH:0] sum;
  logic                arith;
  logic [DATA_WIDTH-1:0] b_eff;

  always_comb begin
    sum   = '0;
    out   = '0;
    arith = 1'b0;
    b_eff = in_b;
    case (opcode)
      ALU_OP_ADD: begin
        arith = 1'b1;
        sum   = {1'b0, in_a} + {1'b0, in_b} + {{DATA_WIDTH{1'b0}}, input_carry};
        out   = sum[DATA_WIDTH-1:0];
      end
      ALU_OP_SUB: begin
        // carry out means no borrow
        arith = 1'b1;
        b_eff = ~in_b;
        sum   = {1'b0, in_a} + {1'b0, b_eff} + {{DATA_WIDTH{1'b0}}, ~input_carry};
        out   = sum[DATA_WIDTH-1:0];
      end
      ALU_OP_AND: out = in_a & in_b;
      ALU_OP_OR:  out = in_a | in_b;
      ALU_OP_XOR: out = in_a ^ in_b;
      default:    out = '0;
    endcase
  end

  always_comb begin
    out_flag          = '0;
    out_flag.carry    = mode & arith & sum[DATA_WIDTH];
    out_flag.zero     = (out == '0);
    out_flag.negative = out[DATA_WIDTH-1];
    out_flag.overflow = mode & arith & (in_a[DATA_WIDTH-1] == b_eff[DATA_WIDTH-1]) &
                        (out[DATA_WIDTH-1] != in_a[DATA_WIDTH-1]);
  end

endmodule

// File: rtl/alu_mul_seq.sv
// Shift-add 16x16->32 multiplier sequencer that borrows the shared ALU for its accumulate steps.
// Define ALU_MUL_SEQ_SIGNED_EN for a signed product (magnitude multiply plus a FIX negate state).
module alu_mul_seq
  import CPU_package::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] product_hi,
  output logic [DATA_WIDTH-1:0] product_lo,
  output logic                  alu_req,
  output logic [DATA_WIDTH-1:0] alu_in_a,
  output logic [DATA_WIDTH-1:0] alu_in_b,
  output logic                  alu_input_carry,
  output enum_alu_opcode_t      alu_opcode,
  output logic                  alu_mode,
  input  logic [DATA_WIDTH-1:0] alu_out,
  input  struct_alu_flag_t      alu_out_flag
);

  enum_mul_state_t       state;
  logic [DATA_WIDTH-1:0] m;
  logic [DATA_WIDTH-1:0] hi;
  logic [DATA_WIDTH-1:0] lo;
  logic [4:0]            cnt;
  logic [DATA_WIDTH-1:0] step_hi;
  logic [DATA_WIDTH-1:0] step_lo;
  logic                  unused_flags;

  // 33-bit right shift of {carry, sum, LO}: carry lands in HI msb, sum lsb moves into LO
  assign step_hi = {alu_out_flag.carry, alu_out[DATA_WIDTH-1:1]};
  assign step_lo = {alu_out[0], lo[DATA_WIDTH-1:1]};

  assign unused_flags = ^{alu_out_flag.zero, alu_out_flag.negative, alu_out_flag.overflow};

`ifdef ALU_MUL_SEQ_SIGNED_EN
  logic                    sign;
  logic [2*DATA_WIDTH-1:0] neg_prod;
  assign neg_prod = ~{hi, lo} + (2*DATA_WIDTH)'(1);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= MUL_IDLE;
      m          <= '0;
      hi         <= '0;
      lo         <= '0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      product_hi <= '0;
      product_lo <= '0;
`ifdef ALU_MUL_SEQ_SIGNED_EN
      sign       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        MUL_IDLE: begin
          if (start) begin
`ifdef ALU_MUL_SEQ_SIGNED_EN
            m    <= abs_val(op_a);
            lo   <= abs_val(op_b);
            sign <= op_a[DATA_WIDTH-1] ^ op_b[DATA_WIDTH-1];
`else
            m    <= op_a;
            lo   <= op_b;
`endif
            hi    <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= MUL_RUN;
          end
        end
        MUL_RUN: begin
          hi  <= step_hi;
          lo  <= step_lo;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd15) begin
`ifdef ALU_MUL_SEQ_SIGNED_EN
            state <= MUL_FIX;
`else
            // product is published on the same edge that enters DONE
            product_hi <= step_hi;
            product_lo <= step_lo;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= MUL_DONE;
`endif
          end
        end
        MUL_FIX: begin
`ifdef ALU_MUL_SEQ_SIGNED_EN
          if (sign) begin
            {hi, lo}                 <= neg_prod;
            {product_hi, product_lo} <= neg_prod;
          end else begin
            {product_hi, product_lo} <= {hi, lo};
          end
`else
          {product_hi, product_lo} <= {hi, lo};
`endif
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= MUL_DONE;
        end
        MUL_DONE: state <= MUL_IDLE;
        default:  state <= MUL_IDLE;
      endcase
    end
  end

  assign alu_req         = busy;
  assign alu_input_carry = 1'b0;
  assign alu_mode        = busy;
  assign alu_opcode      = busy ? ALU_OP_ADD : ALU_OP_AND;
  assign alu_in_a        = busy ? hi : '0;
  assign alu_in_b        = (busy && lo[0]) ? m : '0;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboard bench for alu_mul_seq driving the real ALU; expected products are hand-computed.
// Covers both builds (ALU_MUL_SEQ_SIGNED_EN defined or not).
module tb_alu_mul_seq;
  import CPU_package::*;

`ifdef ALU_MUL_SEQ_SIGNED_EN
  localparam int LAT = 18;
`else
  localparam int LAT = 17;
`endif

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  start = 1'b0;
  logic [DATA_WIDTH-1:0] op_a = '0;
  logic [DATA_WIDTH-1:0] op_b = '0;
  logic                  busy, done, alu_req, alu_input_carry, alu_mode;
  logic [DATA_WIDTH-1:0] product_hi, product_lo, alu_in_a, alu_in_b, alu_out;
  enum_alu_opcode_t      alu_opcode;
  struct_alu_flag_t      alu_out_flag;

  alu_mul_seq dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .product_hi(product_hi), .product_lo(product_lo),
    .alu_req(alu_req), .alu_in_a(alu_in_a), .alu_in_b(alu_in_b),
    .alu_input_carry(alu_input_carry), .alu_opcode(alu_opcode), .alu_mode(alu_mode),
    .alu_out(alu_out), .alu_out_flag(alu_out_flag)
  );

  ALU u_alu (
    .in_a(alu_in_a), .in_b(alu_in_b), .input_carry(alu_input_carry),
    .opcode(alu_opcode), .mode(alu_mode), .out(alu_out), .out_flag(alu_out_flag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] prod;
    int          start_cyc;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      exp_t e;
      tests++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got product %0h at cycle %0d, expected no done",
                 {product_hi, product_lo}, cyc);
      end else begin
        e = sb.pop_front();
        check("product", {product_hi, product_lo}, e.prod);
        check("latency", cyc - e.start_cyc, LAT);
        check("busy_at_done", {31'd0, busy}, 32'd0);
      end
    end
  end

  // repulse > 0 re-asserts start with other operands in that RUN cycle
  task automatic run_mul(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp,
                         input int repulse, input string name);
    int  busy_cnt = 0;
    bit  bus_ok = 1'b1;
    bit  got = 1'b0;
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    sb.push_back('{exp, cyc});
    @(posedge clk);
    #1 start = 1'b0;
    for (int w = 1; w <= 40 && !got; w++) begin
      @(negedge clk);
      start = 1'b0;
      if (w == repulse) begin
        start = 1'b1;
        op_a  = 16'h0007;
        op_b  = 16'h0009;
      end
      if (busy) begin
        busy_cnt++;
        if (alu_req !== 1'b1 || alu_opcode !== ALU_OP_ADD || alu_mode !== 1'b1) bus_ok = 1'b0;
      end else if (alu_req !== 1'b0 || alu_opcode !== ALU_OP_AND || alu_mode !== 1'b0) begin
        bus_ok = 1'b0;
      end
      if (done) got = 1'b1;
    end
    start = 1'b0;
    check({name, "_done_seen"}, {31'd0, got}, 32'd1);
    check({name, "_busy_cycles"}, busy_cnt, LAT - 1);
    check({name, "_bus"}, {31'd0, bus_ok}, 32'd1);
  endtask

  initial begin
    bit got;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_product", {product_hi, product_lo}, 32'd0);
    check("rst_alu_req", {31'd0, alu_req}, 32'd0);
    check("rst_alu_in", {alu_in_a, alu_in_b}, 32'd0);
    check("rst_alu_carry", {31'd0, alu_input_carry}, 32'd0);
    check("rst_alu_opcode", 32'(alu_opcode), 32'(ALU_OP_AND));
    check("rst_alu_mode", {31'd0, alu_mode}, 32'd0);
    rst = 1'b0;

    run_mul(16'd3, 16'd5, 32'h0000_000F, 0, "mul_3x5");
`ifdef ALU_MUL_SEQ_SIGNED_EN
    run_mul(16'hFFFF, 16'hFFFF, 32'h0000_0001, 0, "mul_m1xm1");
    run_mul(16'hFFFD, 16'd5, 32'hFFFF_FFF1, 0, "mul_m3x5");
`else
    run_mul(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 0, "mul_ffffxffff");
    run_mul(16'hFFFD, 16'd5, 32'h0004_FFF1, 0, "mul_fffdx5");
`endif
    run_mul(16'h0000, 16'h1234, 32'h0000_0000, 0, "mul_0x1234");
    run_mul(16'h8000, 16'h8000, 32'h4000_0000, 0, "mul_8000x8000");
    run_mul(16'h00FF, 16'h0101, 32'h0000_FFFF, 0, "mul_ffx101");
    run_mul(16'd3, 16'd5, 32'h0000_000F, 5, "mul_repulse");

    // start held high across DONE: second accept is the IDLE cycle right after DONE
    @(negedge clk);
    op_a  = 16'd2;
    op_b  = 16'd3;
    start = 1'b1;
    sb.push_back('{32'd6, cyc});
    sb.push_back('{32'd20, cyc + LAT + 1});
    @(posedge clk);
    #1 op_a = 16'd4;
    op_b = 16'd5;
    repeat (LAT + 1) @(posedge clk);
    #1 start = 1'b0;
    got = 1'b0;
    for (int w = 0; w < 40 && !got; w++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    check("held_start_second_done", {31'd0, got}, 32'd1);

    // reset in cycle 8 of a run: abort, product cleared, no done afterwards
    @(negedge clk);
    op_a  = 16'h1234;
    op_b  = 16'h5678;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(negedge clk);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_product", {product_hi, product_lo}, 32'd0);
    check("mid_rst_alu_req", {31'd0, alu_req}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    repeat (LAT + 6) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    check("idle_product_after_rst", {product_hi, product_lo}, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
